// File: rtl/seg_pkg.sv
// Shared seven-segment encoding for the display driver and the capture/decoder path.
package seg_pkg;

    localparam int unsigned SEG_W = 7;

    // Segment order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B = 7'b1111100;
    localparam logic [SEG_W-1:0] SEG_C = 7'b0111001;
    localparam logic [SEG_W-1:0] SEG_D = 7'b1011110;
    localparam logic [SEG_W-1:0] SEG_E = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_F = 7'b1110001;

    localparam logic [SEG_W-1:0] MARK_P = 7'b1110011;
    localparam logic [SEG_W-1:0] MARK_Q = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAP_P = 2'd1,
        CAP_Q = 2'd2
    } state_t;

    // Single source of the nibble -> pattern mapping, used by encoder and decoder alike
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        seg = SEG_0;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_to_nibble.sv
// Combinational classifier: segment pattern -> hex digit, frame marker, or unknown.
module seg_to_nibble
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic             o_is_digit,
    output logic             o_is_mark_p,
    output logic             o_is_mark_q,
    output logic [3:0]       o_nibble
);

    always_comb begin
        o_is_digit  = 1'b0;
        o_is_mark_p = (i_seg == MARK_P);
        o_is_mark_q = (i_seg == MARK_Q);
        o_nibble    = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == seg_encode(4'(i))) begin
                o_is_digit = 1'b1;
                o_nibble   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_capture.sv
// Samples a strobed seven-segment stream and reassembles framed P and Q hex words.
module seg_capture
    import seg_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEG_W-1:0]    seg_in,
    input  logic                strobe,
    input  logic                clr_err,
    output logic [4*NDIG-1:0]   p_word,
    output logic [4*NDIG-1:0]   q_word,
    output logic                p_valid,
    output logic                q_valid,
    output logic                busy,
    output logic                err
);

    localparam int unsigned W  = 4 * NDIG;
    localparam int unsigned CW = $clog2(NDIG + 1);

    state_t          r_state, w_state_n;
    logic [W-1:0]    r_shift, w_shift_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [W-1:0]    r_p_word, w_p_word_n;
    logic [W-1:0]    r_q_word, w_q_word_n;
    logic            r_p_valid, w_p_valid_n;
    logic            r_q_valid, w_q_valid_n;
    logic            r_busy, w_busy_n;
    logic            r_err, w_err_n;
    logic            r_strobe_d;

    logic            w_sample;
    logic            w_is_digit, w_is_mark_p, w_is_mark_q;
    logic [3:0]      w_nibble;
    logic [W-1:0]    w_shift_app;

    seg_to_nibble u_dec (
        .i_seg       (seg_in),
        .o_is_digit  (w_is_digit),
        .o_is_mark_p (w_is_mark_p),
        .o_is_mark_q (w_is_mark_q),
        .o_nibble    (w_nibble)
    );

    // History resets high so a strobe already high at reset release is not an edge
    assign w_sample    = strobe & ~r_strobe_d;
    assign w_shift_app = W'({r_shift, w_nibble});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_p_word   <= '0;
            r_q_word   <= '0;
            r_p_valid  <= 1'b0;
            r_q_valid  <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_strobe_d <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_shift    <= w_shift_n;
            r_cnt      <= w_cnt_n;
            r_p_word   <= w_p_word_n;
            r_q_word   <= w_q_word_n;
            r_p_valid  <= w_p_valid_n;
            r_q_valid  <= w_q_valid_n;
            r_busy     <= w_busy_n;
            r_err      <= w_err_n;
            r_strobe_d <= strobe;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_shift_n   = r_shift;
        w_cnt_n     = r_cnt;
        w_p_word_n  = r_p_word;
        w_q_word_n  = r_q_word;
        w_p_valid_n = 1'b0;
        w_q_valid_n = 1'b0;
        w_err_n     = r_err & ~clr_err;

        if (w_sample) begin
            if (w_is_mark_p || w_is_mark_q) begin
                // A marker restarts framing from any state, dropping any partial word
                w_state_n = w_is_mark_p ? CAP_P : CAP_Q;
                w_shift_n = '0;
                w_cnt_n   = '0;
            end else if (w_is_digit) begin
                if (r_state != IDLE) begin
                    if (r_cnt == CW'(NDIG - 1)) begin
                        if (r_state == CAP_P) begin
                            w_p_word_n  = w_shift_app;
                            w_p_valid_n = 1'b1;
                        end else begin
                            w_q_word_n  = w_shift_app;
                            w_q_valid_n = 1'b1;
                        end
                        w_state_n = IDLE;
                        w_shift_n = '0;
                        w_cnt_n   = '0;
                    end else begin
                        w_shift_n = w_shift_app;
                        w_cnt_n   = r_cnt + CW'(1);
                    end
                end
            end else begin
                w_err_n   = 1'b1;
                w_state_n = IDLE;
                w_shift_n = '0;
                w_cnt_n   = '0;
            end
        end

        w_busy_n = (w_state_n != IDLE);
    end

    assign p_word  = r_p_word;
    assign q_word  = r_q_word;
    assign p_valid = r_p_valid;
    assign q_valid = r_q_valid;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule

// File: tb/tb_seg_capture.sv
// Directed self-checking bench for seg_capture with hand-computed expectations.
module tb_seg_capture;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic        strobe;
    logic        clr_err;
    logic [15:0] p_word;
    logic [15:0] q_word;
    logic        p_valid;
    logic        q_valid;
    logic        busy;
    logic        err;

    int checks;
    int errors;
    int p_pulses;
    int q_pulses;
    int p_base;
    int q_base;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111101;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] SA = 7'b1110111;
    localparam logic [6:0] SB = 7'b1111100;
    localparam logic [6:0] SC = 7'b0111001;
    localparam logic [6:0] SD = 7'b1011110;
    localparam logic [6:0] SF = 7'b1110001;
    localparam logic [6:0] MP = 7'b1110011;
    localparam logic [6:0] MQ = 7'b1100111;
    localparam logic [6:0] BAD = 7'b0000001;

    seg_capture #(.NDIG(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg_in  (seg_in),
        .strobe  (strobe),
        .clr_err (clr_err),
        .p_word  (p_word),
        .q_word  (q_word),
        .p_valid (p_valid),
        .q_valid (q_valid),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Valid pulses counted once per clock cycle they are high
    always @(negedge clk) begin
        if (p_valid === 1'b1) p_pulses++;
        if (q_valid === 1'b1) q_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] pat);
        @(negedge clk);
        seg_in = pat;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        p_pulses = 0;
        q_pulses = 0;
        rst      = 1'b1;
        seg_in   = 7'b0;
        strobe   = 1'b0;
        clr_err  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_p_word", 32'(p_word), 32'h0);
        check("rst_q_word", 32'(q_word), 32'h0);
        check("rst_p_valid", 32'(p_valid), 32'h0);
        check("rst_q_valid", 32'(q_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // P word 1234
        p_base = p_pulses;
        send(MP);
        check("mark_p_busy", 32'(busy), 32'h1);
        send(S1); send(S2); send(S3);
        check("p_partial_busy", 32'(busy), 32'h1);
        check("p_partial_word", 32'(p_word), 32'h0);
        send(S4);
        check("p1_word", 32'(p_word), 32'h1234);
        check("p1_pulses", 32'(p_pulses - p_base), 32'h1);
        check("p1_q_word", 32'(q_word), 32'h0);
        check("p1_err", 32'(err), 32'h0);
        check("p1_busy", 32'(busy), 32'h0);

        // Q word ABCD
        q_base = q_pulses;
        p_base = p_pulses;
        send(MQ); send(SA); send(SB); send(SC); send(SD);
        check("q1_word", 32'(q_word), 32'hABCD);
        check("q1_pulses", 32'(q_pulses - q_base), 32'h1);
        check("q1_p_pulses", 32'(p_pulses - p_base), 32'h0);
        check("q1_p_word", 32'(p_word), 32'h1234);

        // Re-mark mid-capture abandons partial word
        p_base = p_pulses;
        send(MP); send(S1); send(S2);
        send(MP); send(S5); send(S6); send(S7); send(S8);
        check("remark_word", 32'(p_word), 32'h5678);
        check("remark_pulses", 32'(p_pulses - p_base), 32'h1);

        // Unknown pattern mid-capture
        send(MP); send(S9); send(BAD);
        check("unk_err", 32'(err), 32'h1);
        check("unk_busy", 32'(busy), 32'h0);
        check("unk_p_word", 32'(p_word), 32'h5678);
        p_base = p_pulses;
        send(SF); send(SF); send(SF); send(SF);
        check("idle_digits_word", 32'(p_word), 32'h5678);
        check("idle_digits_pulses", 32'(p_pulses - p_base), 32'h0);
        check("idle_digits_busy", 32'(busy), 32'h0);
        check("err_sticky", 32'(err), 32'h1);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        check("clr_err", 32'(err), 32'h0);

        // Set wins over clear in the same cycle
        @(negedge clk);
        seg_in  = BAD;
        strobe  = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        strobe  = 1'b0;
        clr_err = 1'b0;
        #1;
        check("set_wins", 32'(err), 32'h1);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        check("clr_err2", 32'(err), 32'h0);

        // Long strobe: one sample only, seg change while high ignored
        @(negedge clk);
        seg_in = MP;
        strobe = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) seg_in = S3;
        end
        strobe = 1'b0;
        @(negedge clk);
        #1;
        check("long_busy", 32'(busy), 32'h1);
        p_base = p_pulses;
        send(S4); send(S3); send(S2);
        check("long_count0_no_early", 32'(p_pulses - p_base), 32'h0);
        send(S1);
        check("long_word", 32'(p_word), 32'h4321);
        check("long_pulses", 32'(p_pulses - p_base), 32'h1);

        // Asynchronous reset mid-capture, strobe high across release
        send(MP); send(S1); send(S2);
        @(negedge clk);
        seg_in = MP;
        strobe = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'h0);
        check("async_p_word", 32'(p_word), 32'h0);
        check("async_q_word", 32'(q_word), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        #1;
        check("rel_no_sample_busy", 32'(busy), 32'h0);

        // Normal operation after reset
        q_base = q_pulses;
        send(MQ); send(S0); send(S0); send(S0); send(SF);
        check("post_rst_q_word", 32'(q_word), 32'h000F);
        check("post_rst_q_pulses", 32'(q_pulses - q_base), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
